// File: rtl/ahfp_cordic_vector.sv
// Vectoring-mode CORDIC: converts a Q2.29 Cartesian vector (x, y) into
// magnitude and atan2(y, x), one micro-rotation per clock, with valid/ready
// handshakes on both the operand and the result side.
module ahfp_cordic_vector #(
  parameter int          N  = 16,
  parameter logic [31:0] AN = 32'h136E9DB4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] magnitude,
  output logic [31:0] angle
);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  localparam logic signed [31:0] PI      = 32'sh6487ED51;
  localparam logic        [4:0]  I_LAST  = 5'(N - 1);

  // round(atan(2^-i) * 2^29); beyond i=9 the value rounds to exactly 2^(29-i)
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sd421657428;
      5'd1:    atan_lut = 32'sd248918915;
      5'd2:    atan_lut = 32'sd131521918;
      5'd3:    atan_lut = 32'sd66762579;
      5'd4:    atan_lut = 32'sd33510843;
      5'd5:    atan_lut = 32'sd16771758;
      5'd6:    atan_lut = 32'sd8387925;
      5'd7:    atan_lut = 32'sd4194219;
      5'd8:    atan_lut = 32'sd2097141;
      5'd9:    atan_lut = 32'sd1048575;
      default: atan_lut = 32'sd1 <<< (5'd29 - idx);
    endcase
  endfunction

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic        [4:0]  i_q, i_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic        [31:0] magnitude_q, magnitude_d;
  logic        [31:0] angle_q, angle_d;

  logic signed [31:0] x_sh, y_sh, atan_i;
  logic signed [63:0] x_ext, an_ext, prod;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    out_valid_d = out_valid_q;
    magnitude_d = magnitude_q;
    angle_d     = angle_q;

    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = atan_lut(i_q);
    x_ext  = {{32{x_q[31]}}, x_q};
    an_ext = {{32{AN[31]}}, AN};
    prod   = x_ext * an_ext;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // fold the left half-plane onto the right so iterations converge
          if (!x_in[31]) begin
            x_d = $signed(x_in);
            y_d = $signed(y_in);
            z_d = '0;
          end else begin
            x_d = -$signed(x_in);
            y_d = -$signed(y_in);
            z_d = y_in[31] ? -PI : PI;
          end
          i_d     = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (!y_q[31]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        i_d = i_q + 5'd1;
        if (i_q == I_LAST) state_d = SCALE;
      end
      SCALE: begin
        // x carries the CORDIC gain; multiply by 1/gain and drop the Q2.29 fraction
        magnitude_d = 32'(prod >>> 29);
        angle_d     = z_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      magnitude_q <= '0;
      angle_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      magnitude_q <= magnitude_d;
      angle_q     <= angle_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign magnitude = magnitude_q;
  assign angle     = angle_q;

endmodule
